// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM bus initiator.
package sram_ctrl_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 32;
    localparam int WAIT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Bus initiator for one asynchronous 1M x 32 SRAM; every output is registered.
// Define SRAM_CTRL_POSTED_WRITE_EN to acknowledge writes in the WR_SETUP cycle.
//
//   state    | meaning
//   IDLE     | strobes released, req_ready=1, rsp_valid pulses here
//   RD       | ce_n/oe_n low for READ_WAIT+1 cycles, data sampled on the last edge
//   WR_SETUP | ce_n low, data driven, we_n still high
//   WR_PULSE | we_n low for WRITE_WAIT+1 cycles
//   WR_HOLD  | we_n high again, address/data/ce_n held one more cycle
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [SRAM_AW-1:0] req_addr,
    input  logic [3:0]         req_wstrb,
    input  logic [SRAM_DW-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [SRAM_DW-1:0] rsp_rdata,
    output logic [SRAM_AW-1:0] ram_addr,
    input  logic [SRAM_DW-1:0] ram_data_in,
    output logic [SRAM_DW-1:0] ram_data_out,
    output logic               ram_data_oe,
    output logic               ram_ce_n,
    output logic               ram_oe_n,
    output logic               ram_we_n,
    output logic [3:0]         ram_be_n
);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   cnt, cnt_nxt;
    logic                ready_nxt, rsp_valid_nxt, data_oe_nxt;
    logic                ce_nxt, oen_nxt, wen_nxt;
    logic [3:0]          be_nxt;
    logic [SRAM_AW-1:0]  addr_nxt;
    logic [SRAM_DW-1:0]  dout_nxt, rdata_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            ram_addr     <= '0;
            ram_data_out <= '0;
            ram_data_oe  <= 1'b0;
            ram_ce_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            ram_be_n     <= 4'hF;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            req_ready    <= ready_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_rdata    <= rdata_nxt;
            ram_addr     <= addr_nxt;
            ram_data_out <= dout_nxt;
            ram_data_oe  <= data_oe_nxt;
            ram_ce_n     <= ce_nxt;
            ram_oe_n     <= oen_nxt;
            ram_we_n     <= wen_nxt;
            ram_be_n     <= be_nxt;
        end
    end

    // Next values describe the pins for the cycle after the coming edge.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ready_nxt     = req_ready;
        rsp_valid_nxt = 1'b0;
        rdata_nxt     = rsp_rdata;
        addr_nxt      = ram_addr;
        dout_nxt      = ram_data_out;
        data_oe_nxt   = ram_data_oe;
        ce_nxt        = ram_ce_n;
        oen_nxt       = ram_oe_n;
        wen_nxt       = ram_we_n;
        be_nxt        = ram_be_n;
        unique case (state)
            IDLE: begin
                ready_nxt   = 1'b1;
                ce_nxt      = 1'b1;
                oen_nxt     = 1'b1;
                wen_nxt     = 1'b1;
                be_nxt      = 4'hF;
                data_oe_nxt = 1'b0;
                if (req_valid && req_ready) begin
                    ready_nxt = 1'b0;
                    ce_nxt    = 1'b0;
                    addr_nxt  = req_addr;
                    if (req_we) begin
                        state_nxt   = WR_SETUP;
                        data_oe_nxt = 1'b1;
                        dout_nxt    = req_wdata;
                        be_nxt      = ~req_wstrb;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
                        rsp_valid_nxt = 1'b1;
                        rdata_nxt     = '0;
`endif
                    end else begin
                        state_nxt = RD;
                        oen_nxt   = 1'b0;
                        be_nxt    = 4'h0;
                        cnt_nxt   = WAIT_W'(READ_WAIT);
                    end
                end
            end
            RD: begin
                if (cnt == '0) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b1;
                    rdata_nxt     = ram_data_in;
                    ce_nxt        = 1'b1;
                    oen_nxt       = 1'b1;
                    be_nxt        = 4'hF;
                    ready_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                wen_nxt   = 1'b0;
                cnt_nxt   = WAIT_W'(WRITE_WAIT);
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = WR_HOLD;
                    wen_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end
            end
            WR_HOLD: begin
                state_nxt   = IDLE;
                ce_nxt      = 1'b1;
                data_oe_nxt = 1'b0;
                be_nxt      = 4'hF;
                ready_nxt   = 1'b1;
`ifndef SRAM_CTRL_POSTED_WRITE_EN
                rsp_valid_nxt = 1'b1;
                rdata_nxt     = '0;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: SRAM responder model, transaction-level
// reference memory and per-transaction pin/latency checks.
module tb_sram_ctrl;

    localparam int RW = 1;
    localparam int WW = 1;

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we;
    logic [19:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [19:0] ram_addr;
    logic [31:0] ram_data_in, ram_data_out;
    logic        ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
    logic [3:0]  ram_be_n;

    sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .ram_be_n(ram_be_n)
    );

    always #5 clk = ~clk;

    // SRAM responder: data only becomes valid after oe_n has been low RW cycles.
    logic [31:0] sram [0:1048575];
    int          rd_cnt = 0;

    function automatic logic [31:0] pin_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be_n);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++)
            if (!be_n[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (ram_ce_n === 1'b0 && ram_oe_n === 1'b0) rd_cnt <= rd_cnt + 1;
        else rd_cnt <= 0;
        if (ram_ce_n === 1'b0 && ram_we_n === 1'b0)
            sram[ram_addr] <= pin_merge(sram[ram_addr], ram_data_out, ram_be_n);
    end

    assign ram_data_in = (ram_ce_n === 1'b0 && ram_oe_n === 1'b0 && rd_cnt >= RW)
                         ? sram[ram_addr] : 32'hA5A5_5A5A;

    // Reference memory at transaction level
    logic [31:0] ref_mem [logic [19:0]];

    function automatic logic [31:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_write(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle-time %0t)", tag, got, exp, $time);
    endtask

    // Global pin-protocol monitor
    int   ovl_cnt = 0, oe_bad_cnt = 0, stab_cnt = 0;
    logic prev_lo = 1'b0;
    logic [19:0] prev_addr;
    logic [31:0] prev_dout;
    logic [3:0]  prev_be;

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (ram_oe_n === 1'b0 && ram_we_n === 1'b0) ovl_cnt++;
            if (ram_data_oe === 1'b1 && (ram_ce_n !== 1'b0 || ram_oe_n !== 1'b1)) oe_bad_cnt++;
            if (ram_ce_n === 1'b0 && prev_lo &&
                (ram_addr !== prev_addr || ram_be_n !== prev_be || ram_data_out !== prev_dout))
                stab_cnt++;
            prev_lo   = (ram_ce_n === 1'b0);
            prev_addr = ram_addr;
            prev_be   = ram_be_n;
            prev_dout = ram_data_out;
        end else begin
            prev_lo = 1'b0;
        end
    end

    // Driver / transaction tracking state
    req_t stim_q[$];
    rsp_t rsp_q[$];
    req_t pres, cur;
    int   cyc = 0, exp_acc = -1, present_cyc = 0;
    int   cur_acc = 0, cur_done = 0, ce_lo = 0, we_lo = 0, pin_bad = 0;
    bit   cur_act = 0, accepted_last = 0, chain = 0;
    logic [19:0] pool [8];

    task automatic present(input req_t r);
        pres        = r;
        req_valid   = 1'b1;
        req_we      = r.we;
        req_addr    = r.addr;
        req_wstrb   = r.strb;
        req_wdata   = r.wdata;
        present_cyc = cyc;
    endtask

    task automatic tick();
        rsp_t e;
        @(negedge clk);
        cyc++;
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_cycle", cyc, e.cyc);
                check("rsp_rdata", rsp_rdata, e.data);
            end
        end else if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            check("rsp_missing", cyc, rsp_q[0].cyc);
            void'(rsp_q.pop_front());
        end
        if (cur_act) begin
            if (cyc == cur_done) begin
                check("ce_low_cycles", ce_lo, cur.we ? WW + 3 : RW + 1);
                check("we_low_cycles", we_lo, cur.we ? WW + 1 : 0);
                check("pins_during_txn", pin_bad, 0);
                check("ce_n_deselect", {31'd0, ram_ce_n}, 32'd1);
                cur_act = 0;
            end else begin
                if (ram_ce_n === 1'b0) ce_lo++;
                if (ram_we_n === 1'b0) we_lo++;
                if (ram_addr !== cur.addr || req_ready !== 1'b0) pin_bad++;
                if (cur.we) begin
                    if (ram_be_n !== ~cur.strb || ram_data_out !== cur.wdata ||
                        ram_data_oe !== 1'b1 || ram_oe_n !== 1'b1) pin_bad++;
                end else begin
                    if (ram_be_n !== 4'h0 || ram_data_oe !== 1'b0 ||
                        ram_oe_n !== 1'b0 || ram_we_n !== 1'b1) pin_bad++;
                end
            end
        end
        if (accepted_last) begin
            accepted_last = 0;
            if (chain && stim_q.size() > 0) begin
                present(stim_q.pop_front());
                exp_acc = cur_done;
            end else begin
                req_valid = 1'b0;
            end
        end else if (!req_valid && !cur_act && stim_q.size() > 0 &&
                     (chain || $urandom_range(0, 1) == 0)) begin
            present(stim_q.pop_front());
            exp_acc = -1;
        end
        if (req_valid && req_ready === 1'b1) begin
            if (exp_acc >= 0) check("b2b_accept_cycle", cyc, exp_acc);
            cur     = pres;
            cur_acc = cyc;
            cur_act = 1;
            ce_lo   = 0;
            we_lo   = 0;
            pin_bad = 0;
            if (pres.we) begin
                ref_mem[pres.addr] = ref_write(ref_rd(pres.addr), pres.wdata, pres.strb);
                e.data   = 32'h0;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
                e.cyc    = cyc + 1;
`else
                e.cyc    = cyc + WW + 4;
`endif
                cur_done = cyc + WW + 4;
            end else begin
                e.data   = ref_rd(pres.addr);
                e.cyc    = cyc + RW + 2;
                cur_done = e.cyc;
            end
            rsp_q.push_back(e);
            accepted_last = 1;
        end else if (req_valid && cyc - present_cyc > 40) begin
            check("ready_timeout", cyc - present_cyc, 32'd0);
            req_valid = 1'b0;
        end
    endtask

    task automatic run(input bit ch);
        int n;
        n = 0;
        chain = ch;
        while ((stim_q.size() > 0 || req_valid || cur_act || rsp_q.size() > 0 || accepted_last)
               && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("run_timeout", n, 32'd0);
        tick();
    endtask

    function automatic req_t mk(input logic we, input logic [19:0] a, input logic [3:0] s,
                                input logic [31:0] d);
        req_t r;
        r.we = we; r.addr = a; r.strb = s; r.wdata = d;
        return r;
    endfunction

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pool = '{20'h00010, 20'h00011, 20'h80000, 20'h7FFFF,
                 20'h12345, 20'hABCDE, 20'h00F00, 20'hFFFFE};
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wstrb = '0; req_wdata = '0;
        repeat (3) tick();
        check("rst_ce_n", {31'd0, ram_ce_n}, 32'd1);
        check("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
        check("rst_we_n", {31'd0, ram_we_n}, 32'd1);
        check("rst_be_n", {28'd0, ram_be_n}, 32'hF);
        check("rst_data_oe", {31'd0, ram_data_oe}, 32'd0);
        check("rst_addr", {12'd0, ram_addr}, 32'd0);
        check("rst_data_out", ram_data_out, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        resetn = 1'b1;
        repeat (2) tick();
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Directed write/read, byte strobes and an all-zero strobe write
        stim_q.push_back(mk(1'b1, 20'h00010, 4'hF, 32'hDEADBEEF));
        stim_q.push_back(mk(1'b0, 20'h00010, 4'h0, 32'h0));
        stim_q.push_back(mk(1'b1, 20'h00010, 4'b0101, 32'h11223344));
        stim_q.push_back(mk(1'b0, 20'h00010, 4'h0, 32'h0));
        stim_q.push_back(mk(1'b1, 20'h00010, 4'h0, 32'hFFFFFFFF));
        stim_q.push_back(mk(1'b0, 20'h00010, 4'h0, 32'h0));
        run(1'b0);

        // Back-to-back alternating requests with req_valid held high
        stim_q.push_back(mk(1'b1, 20'h12345, 4'hF, 32'hAAAA5555));
        stim_q.push_back(mk(1'b0, 20'h12345, 4'h0, 32'h0));
        stim_q.push_back(mk(1'b1, 20'h00011, 4'hF, 32'h0BADF00D));
        stim_q.push_back(mk(1'b0, 20'h00011, 4'h0, 32'h0));
        run(1'b1);

        // Reset in the middle of a write pulse
        stim_q.push_back(mk(1'b1, 20'h55555, 4'hF, 32'hCAFEF00D));
        chain = 1'b0;
        n = 0;
        while (!(cur_act && cyc == cur_acc + 2) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("reset_test_timeout", n, 32'd0);
        resetn = 1'b0;
        req_valid = 1'b0;
        cur_act = 0;
        accepted_last = 0;
        rsp_q.delete();
        tick();
        check("midrst_we_n", {31'd0, ram_we_n}, 32'd1);
        check("midrst_ce_n", {31'd0, ram_ce_n}, 32'd1);
        check("midrst_data_oe", {31'd0, ram_data_oe}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (2) tick();
        check("ready_after_midrst", {31'd0, req_ready}, 32'd1);

        // Fill the remaining pool, then randomized mixed traffic
        for (int k = 2; k < 8; k++) stim_q.push_back(mk(1'b1, pool[k], 4'hF, $urandom));
        run(1'b1);
        for (int rep = 0; rep < 4; rep++) begin
            for (int k = 0; k < 12; k++) begin
                stim_q.push_back(mk(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                                    4'($urandom_range(0, 15)), $urandom));
            end
            run(1'($urandom_range(0, 1)));
        end

        check("oe_we_overlap", ovl_cnt, 32'd0);
        check("data_oe_outside_write", oe_bad_cnt, 32'd0);
        check("pins_stable_while_selected", stab_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
